rd_window_arbiter: RTL and testbench
====================================

Name: rd_window_arbiter

Overview:
- Round-robin arbiter sharing one single-entry read buffer between NUM_REQ requesters.
- Sequences the consumer-side rd/rd_ack handshake for that buffer.
- Holds data stable from rd assertion until rd_ack, so the window-unchange property on data is guaranteed by construction.
- Sits between the requester agents and the consumer; the ovl window-unchange checker is bound on its rd, data and rd_ack outputs/inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 4, data width per requester.
- TIMEOUT, 15, ISSUE cycles without rd_ack before abort; 0 disables timeout.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- req_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  one-hot, one-cycle completion pulse to owner.
- owner  output  $clog2(NUM_REQ)  index of current/last owner.
- busy  output  1  high while state is not IDLE.
- rd  output  1  start_event to consumer; data valid and stable while high.
- data  output  WIDTH  registered read data.
- rd_ack  input  1  end_event from consumer.
- timeout_err  output  1  one-cycle pulse on abort.
- stray_ack  output  1  one-cycle pulse when rd_ack is seen outside ISSUE.

Behaviour:
- Reset state: all outputs 0, RR pointer 0, state IDLE, timeout counter 0.
- Reset applies immediately and asynchronously, including mid-ISSUE.
- States: IDLE, ISSUE, DONE. All outputs are registered.
- IDLE, any req bit high at an edge:
  - Select the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - data <= that requester's req_data; owner <= index; rd <= 1; counter <= 0; go to ISSUE.
- IDLE, no req: hold all state.
- ISSUE, rd_ack high at an edge:
  - rd <= 0; gnt[owner] <= 1; pointer <= (owner+1) mod NUM_REQ; go to DONE.
- ISSUE, no rd_ack, TIMEOUT != 0 and counter == TIMEOUT-1:
  - rd <= 0; timeout_err <= 1; pointer advances as on completion; no gnt; go to DONE.
- ISSUE otherwise: counter increments (saturating); data and owner hold.
- rd_ack and timeout on the same edge: ack wins; no timeout_err.
- DONE: gnt and timeout_err clear; go to IDLE. DONE is a mandatory gap cycle.
- Timing:
  - rd is high for at least 1 cycle.
  - Minimum rd low time between transactions is 2 cycles.
  - Latency from req sampled to rd high is 1 edge.
- data is written only on the IDLE->ISSUE edge. Changes on req_data or req during ISSUE/DONE are ignored; a requester dropping req mid-ISSUE does not cancel the transaction.
- rd_ack high at an edge in IDLE or DONE: stray_ack <= 1 for one cycle; no state change.
- A level-held rd_ack spanning ISSUE->DONE->IDLE flags stray_ack only in the DONE/IDLE cycles it is sampled.
- The owner keeps req high to re-request; the pointer ensures other pending requesters are served first.
- busy = (state != IDLE).

Test Plan:
- Single requester: reset released; req[1]=1, req_data[1]=4'b1100; rd_ack raised 5 cycles after rd.
  -> rd high 1 edge after req, data=4'b1100, owner=1, gnt=4'b0010 for 1 cycle after ack, rd low.
- Contention: req=4'b1011 held, ack 2 cycles after each rd.
  -> service order 0,1,3,0; every rd rise preceded by ≥2 low cycles.
- Data stability: change req_data[owner] every cycle during ISSUE.
  -> data constant from rd rise to ack; bound ovl_win_unchange (width 4, start rd, end rd_ack) never fires.
- Timeout: TIMEOUT=15, no ack.
  -> rd high exactly 15 cycles, timeout_err pulse, no gnt, next requester served; repeat with ack on cycle 15 -> gnt, no timeout_err.
- Stray ack: pulse rd_ack while idle.
  -> stray_ack 1 cycle, rd stays 0, state IDLE.
- Reset mid-ISSUE: assert reset between edges.
  -> rd, gnt, data, owner, busy 0 immediately; first grant after release goes to lowest set req bit (pointer 0).

Source files
------------

// File: rtl/rd_window_arbiter.sv
// Round-robin arbiter sharing one single-entry read buffer between NUM_REQ requesters.
// Captures the winner's data once and keeps it stable for the whole rd..rd_ack window.
module rd_window_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       rd,
  output logic [WIDTH-1:0]           data,
  input  logic                       rd_ack,
  output logic                       timeout_err,
  output logic                       stray_ack
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0]      CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0]      CNT_MAX  = '1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [1:0]       state;
  logic [IW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic [IW-1:0]    ptr_next;
  logic             timeout_hit;

  // Search upward from ptr with wrap; iterating from the far end lets the
  // nearest set bit overwrite any later candidate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin : search
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(j);
      end
    end
  end

  assign sel_data    = req_data[int'(sel_idx)*WIDTH +: WIDTH];
  assign ptr_next    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // NOTE: reset is asynchronous and clears every register, so rd/data/owner drop the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      owner       <= '0;
      busy        <= 1'b0;
      rd          <= 1'b0;
      data        <= '0;
      timeout_err <= 1'b0;
      stray_ack   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      gnt         <= '0;
      timeout_err <= 1'b0;
      stray_ack   <= 1'b0;
      case (state)
        IDLE: begin
          stray_ack <= rd_ack;
          if (sel_valid) begin
            data  <= sel_data;
            owner <= sel_idx;
            rd    <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Ack has priority over a timeout expiring on the same edge.
          if (rd_ack) begin
            rd         <= 1'b0;
            gnt        <= ONE_HOT0 << owner;
            ptr        <= ptr_next;
            state      <= DONE;
          end else if (timeout_hit) begin
            rd          <= 1'b0;
            timeout_err <= 1'b1;
            ptr         <= ptr_next;
            state       <= DONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          stray_ack <= rd_ack;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rd    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_window_arbiter.sv
// Self-checking bench for rd_window_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_rd_window_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int IW      = $clog2(NUM_REQ);

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic [IW-1:0]            owner;
  logic                     busy;
  logic                     rd;
  logic [WIDTH-1:0]         data;
  logic                     rd_ack;
  logic                     timeout_err;
  logic                     stray_ack;

  always #5 clk = ~clk;

  rd_window_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .owner(owner), .busy(busy), .rd(rd), .data(data), .rd_ack(rd_ack),
    .timeout_err(timeout_err), .stray_ack(stray_ack)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase 0 = waiting, 1 = transfer outstanding, 2 = gap cycle.
  int               m_phase, m_ptr, m_age, m_owner;
  logic             m_rd, m_terr, m_stray, m_busy;
  logic [WIDTH-1:0] m_data;
  logic [NUM_REQ-1:0] m_gnt;

  logic prev_rd;
  int   lo, hi;
  bit   rose, terr_seen, gnt_seen;
  int   rise_owner[$];
  int   first_owner;
  logic [WIDTH-1:0] captured;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_age = 0; m_owner = 0;
    m_rd = 0; m_terr = 0; m_stray = 0; m_busy = 0; m_data = '0; m_gnt = '0;
    prev_rd = 0; lo = 2; hi = 0;
  endtask

  task automatic model_edge(logic [NUM_REQ-1:0] r, logic a, logic [NUM_REQ*WIDTH-1:0] d);
    case (m_phase)
      0: begin
        m_stray = a; m_gnt = '0; m_terr = 0;
        if (r != '0) begin
          int j;
          j = 0;
          for (int k = NUM_REQ - 1; k >= 0; k--)
            if (r[(m_ptr + k) % NUM_REQ]) j = (m_ptr + k) % NUM_REQ;
          m_owner = j;
          m_data  = d[j*WIDTH +: WIDTH];
          m_rd = 1; m_age = 0; m_phase = 1; m_busy = 1;
        end
      end
      1: begin
        m_stray = 0;
        if (a) begin
          m_rd = 0; m_gnt = NUM_REQ'(1 << m_owner);
          m_ptr = (m_owner + 1) % NUM_REQ; m_phase = 2;
        end else if (TIMEOUT != 0 && m_age == TIMEOUT - 1) begin
          m_rd = 0; m_terr = 1;
          m_ptr = (m_owner + 1) % NUM_REQ; m_phase = 2;
        end else begin
          m_age++;
        end
      end
      default: begin
        m_gnt = '0; m_terr = 0; m_stray = a; m_phase = 0; m_busy = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check("rd", rd, m_rd);
    check("data", data, m_data);
    check("owner", owner, m_owner);
    check("gnt", gnt, m_gnt);
    check("busy", busy, m_busy);
    check("timeout_err", timeout_err, m_terr);
    check("stray_ack", stray_ack, m_stray);
  endtask

  task automatic step();
    logic [NUM_REQ-1:0]       r;
    logic                     a;
    logic [NUM_REQ*WIDTH-1:0] d;
    r = req; a = rd_ack; d = req_data;
    @(posedge clk);
    model_edge(r, a, d);
    #1;
    compare_all();
    rose = rd && !prev_rd;
    if (rose) begin
      check("rd_low_gap", lo >= 2, 1);
      lo = 0; hi = 1;
    end else if (rd) begin
      hi++;
    end else begin
      lo++;
    end
    if (timeout_err) terr_seen = 1;
    if (gnt != '0) gnt_seen = 1;
    prev_rd = rd;
  endtask

  // Reset is raised between edges and must clear outputs without waiting for a clock.
  task automatic reset_mid();
    #3 reset = 1'b1;
    #1;
    check("rst_rd", rd, 0);
    check("rst_gnt", gnt, 0);
    check("rst_data", data, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_stray", stray_ack, 0);
    model_reset();
    #2 reset = 1'b0;
  endtask

  task automatic wait_rise(string tag, int bound);
    int n;
    n = 0;
    rose = 0;
    while (!rose && n < bound) begin
      step();
      n++;
    end
    check(tag, rose, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset = 1'b1; req = '0; req_data = '0; rd_ack = 1'b0;
    #22;
    check("reset_rd", rd, 0);
    check("reset_busy", busy, 0);
    check("reset_gnt", gnt, 0);
    check("reset_owner", owner, 0);
    reset = 1'b0;

    // Single requester, ack on the fifth edge after rd rises.
    req = 4'b0010; req_data = 16'h00C0;
    step();
    check("single_rd", rd, 1);
    check("single_data", data, 4'b1100);
    check("single_owner", owner, 1);
    repeat (4) step();
    rd_ack = 1'b1; req = '0;
    step();
    check("single_gnt", gnt, 4'b0010);
    check("single_rd_low", rd, 0);
    rd_ack = 1'b0;
    step();
    check("single_gnt_clear", gnt, 0);

    // Contention from a fresh pointer: expect 0,1,3,0.
    reset_mid();
    req = 4'b1011; req_data = 16'h9A5F;
    rise_owner.delete();
    for (int n = 0; n < 60 && rise_owner.size() < 4; n++) begin
      rd_ack = rd && (hi == 2);
      step();
      if (rose) rise_owner.push_back(int'(owner));
    end
    check("cont_count", rise_owner.size(), 4);
    if (rise_owner.size() == 4) begin
      check("cont_order0", rise_owner[0], 0);
      check("cont_order1", rise_owner[1], 1);
      check("cont_order2", rise_owner[2], 3);
      check("cont_order3", rise_owner[3], 0);
    end
    req = '0;
    for (int n = 0; n < 20 && busy; n++) begin
      rd_ack = rd;
      step();
    end
    rd_ack = 1'b0;
    step();

    // Data must hold while the owner's req_data churns.
    req = 4'b0100; req_data = 16'h0700;
    wait_rise("stab_rise", 10);
    captured = 4'h7;
    for (int n = 0; n < 6; n++) begin
      req_data = 16'($urandom);
      req = 4'($urandom);
      step();
      check("stab_data", data, captured);
    end
    rd_ack = 1'b1; req = '0;
    step();
    rd_ack = 1'b0;
    step();

    // Timeout: no ack for the first transfer, ack on cycle 15 for the next.
    reset_mid();
    req = 4'b0011; req_data = 16'h00E1;
    wait_rise("to_rise1", 10);
    first_owner = int'(owner);
    check("to_first_owner", first_owner, 0);
    terr_seen = 0; gnt_seen = 0;
    for (int n = 0; n < 40 && rd; n++) step();
    check("to_rd_high_len", hi, 15);
    step();
    check("to_terr_seen", terr_seen, 1);
    check("to_no_gnt", gnt_seen, 0);
    wait_rise("to_rise2", 10);
    check("to_next_owner", owner, 1);
    terr_seen = 0; gnt_seen = 0;
    for (int n = 0; n < 40 && rd; n++) begin
      rd_ack = (hi == 15);
      step();
    end
    rd_ack = 1'b0; req = '0;
    step();
    check("ack15_gnt_seen", gnt_seen, 1);
    check("ack15_no_terr", terr_seen, 0);
    step();

    // Stray ack while idle.
    rd_ack = 1'b1;
    step();
    check("stray_pulse", stray_ack, 1);
    check("stray_rd", rd, 0);
    check("stray_busy", busy, 0);
    rd_ack = 1'b0;
    step();
    check("stray_clear", stray_ack, 0);

    // Reset mid-ISSUE, then the pointer restarts at 0.
    req = 4'b1000;
    wait_rise("rmid_rise", 10);
    check("rmid_rd_before", rd, 1);
    req = 4'b0110;
    reset_mid();
    step();
    check("rmid_owner", owner, 1);
    check("rmid_rd_after", rd, 1);

    // Random traffic with varying ack density.
    for (int blk = 0; blk < 4; blk++) begin
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 3) == 0) req = 4'($urandom);
        req_data = 16'($urandom);
        case (blk)
          0: rd_ack = ($urandom_range(0, 1) == 0);
          1: rd_ack = ($urandom_range(0, 7) == 0);
          2: rd_ack = ($urandom_range(0, 24) == 0);
          default: rd_ack = rd && ($urandom_range(0, 2) == 0);
        endcase
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
